// File: rtl/mux_row_scheduler.sv
// mux_row_scheduler: row-scan sequencer that steps the display-row mux and hands each row to the driver.
// Optional row masking is compiled in when MUXSCHED_ROWMASK_EN is defined.
module mux_row_scheduler #(
  parameter int NROWS    = 10,
  parameter int SEL_W    = 4,
  parameter int DATA_W   = 8,
  parameter int TICK_DIV = 5000
) (
  input  logic              CC_MUXSCHED_CLOCK_50,
  input  logic              CC_MUXSCHED_RESET_InLow,
  input  logic              enable_In,
  output logic [SEL_W-1:0]  select_OutBUS,
  input  logic [DATA_W-1:0] row_data_InBUS,
  output logic [DATA_W-1:0] row_data_OutBUS,
  output logic [SEL_W-1:0]  row_index_OutBUS,
  output logic              row_valid_Out,
  input  logic              row_ready_In,
  output logic              frame_done_Out,
`ifdef MUXSCHED_ROWMASK_EN
  input  logic [NROWS-1:0]  row_mask_InBUS,
`endif
  output logic              busy_Out
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [SEL_W-1:0] LAST_ROW  = SEL_W'(NROWS - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, WAIT} stateT;

  stateT             state, stateNext;
  logic [SEL_W-1:0]  selectQ, selectNext;
  logic [SEL_W-1:0]  indexQ, indexNext;
  logic [DATA_W-1:0] dataQ, dataNext;
  logic              validQ, validNext;
  logic              doneQ, doneNext;
  logic [CNT_W-1:0]  holdCount, holdCountNext;
  logic [SEL_W-1:0]  nextRow;
  logic              rowSkip;
  logic              lastRow;

`ifdef MUXSCHED_ROWMASK_EN
  assign rowSkip = row_mask_InBUS[selectQ];
`else
  assign rowSkip = 1'b0;
`endif

  assign lastRow = (selectQ == LAST_ROW);
  assign nextRow = lastRow ? '0 : selectQ + 1'b1;

  always_ff @(posedge CC_MUXSCHED_CLOCK_50 or negedge CC_MUXSCHED_RESET_InLow) begin
    if (!CC_MUXSCHED_RESET_InLow) begin
      state     <= IDLE;
      selectQ   <= '0;
      indexQ    <= '0;
      dataQ     <= '0;
      validQ    <= 1'b0;
      doneQ     <= 1'b0;
      holdCount <= '0;
    end else begin
      state     <= stateNext;
      selectQ   <= selectNext;
      indexQ    <= indexNext;
      dataQ     <= dataNext;
      validQ    <= validNext;
      doneQ     <= doneNext;
      holdCount <= holdCountNext;
    end
  end

  always_comb begin
    stateNext     = state;
    selectNext    = selectQ;
    indexNext     = indexQ;
    dataNext      = dataQ;
    validNext     = validQ;
    doneNext      = 1'b0;
    holdCountNext = holdCount;

    case (state)
      IDLE: begin
        selectNext = '0;
        validNext  = 1'b0;
        if (enable_In) stateNext = SETTLE;
      end

      SETTLE: begin
        // A masked row still consumes SETTLE + WAIT so scan timing stays uniform.
        if (rowSkip) begin
          selectNext    = nextRow;
          holdCountNext = HOLD_LOAD;
          doneNext      = lastRow;
          stateNext     = WAIT;
        end else begin
          dataNext  = row_data_InBUS;
          indexNext = selectQ;
          validNext = 1'b1;
          stateNext = PRESENT;
        end
      end

      PRESENT: begin
        if (validQ && row_ready_In) begin
          validNext     = 1'b0;
          selectNext    = nextRow;
          holdCountNext = HOLD_LOAD;
          doneNext      = lastRow;
          stateNext     = WAIT;
        end
      end

      WAIT: begin
        if (holdCount == '0) begin
          if (enable_In) begin
            stateNext = SETTLE;
          end else begin
            selectNext = '0;
            stateNext  = IDLE;
          end
        end else begin
          holdCountNext = holdCount - 1'b1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  assign select_OutBUS    = selectQ;
  assign row_data_OutBUS  = dataQ;
  assign row_index_OutBUS = indexQ;
  assign row_valid_Out    = validQ;
  assign frame_done_Out   = doneQ;
  assign busy_Out         = (state != IDLE);

endmodule

// File: tb/tb_mux_row_scheduler.sv
// tb_mux_row_scheduler: vector table, hand-written corner sequences and a randomized run
// against a schedule-based reference model of the row scanner (TICK_DIV = 4).
module tb_mux_row_scheduler;
  localparam int NR = 10;
  localparam int SW = 4;
  localparam int DW = 8;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          enable = 1'b0;
  logic          ready = 1'b0;
  logic [SW-1:0] sel, rowIdx;
  logic [DW-1:0] muxOut, rowData;
  logic          rowValid, frameDone, busy;
  logic [NR-1:0] rowMask = '0;
  logic [DW-1:0] muxRows [NR];

  int unsigned passCnt = 0;
  int unsigned checkCnt = 0;

  always #5 clk = ~clk;

  assign muxOut = (sel < SW'(NR)) ? muxRows[sel] : 8'hEE;

  mux_row_scheduler #(.NROWS(NR), .SEL_W(SW), .DATA_W(DW), .TICK_DIV(TD)) dut (
    .CC_MUXSCHED_CLOCK_50   (clk),
    .CC_MUXSCHED_RESET_InLow(rstN),
    .enable_In              (enable),
    .select_OutBUS          (sel),
    .row_data_InBUS         (muxOut),
    .row_data_OutBUS        (rowData),
    .row_index_OutBUS       (rowIdx),
    .row_valid_Out          (rowValid),
    .row_ready_In           (ready),
    .frame_done_Out         (frameDone),
`ifdef MUXSCHED_ROWMASK_EN
    .row_mask_InBUS         (rowMask),
`endif
    .busy_Out               (busy)
  );

  typedef struct {
    logic en;
    logic rdy;
    logic v;
    int   idx;
    int   data;
    int   s;
    logic done;
    logic bsy;
  } vecT;

  vecT tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
  endtask

  function automatic logic [31:0] outVec();
    return {13'd0, rowValid, rowIdx, rowData, sel, frameDone, busy};
  endfunction

  function automatic logic [31:0] expVec(input logic v, input int idx, input int data,
                                         input int s, input logic d, input logic b);
    return {13'd0, v, idx[3:0], data[7:0], s[3:0], d, b};
  endfunction

  function automatic vecT mk(input logic en, input logic rdy, input logic v, input int idx,
                             input int data, input int s, input logic d, input logic b);
    vecT r;
    r.en = en; r.rdy = rdy; r.v = v; r.idx = idx; r.data = data; r.s = s; r.done = d; r.bsy = b;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    enable = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  // Runs cycles with the given ready until the requested row is on offer.
  task automatic waitRow(input int idx, input logic rdy, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rowValid && rowIdx == SW'(idx)) begin
        ok = 1'b1;
        break;
      end
      ready = rdy;
      tick();
    end
  endtask

  // Reference model: rows are scheduled as absolute cycle events.
  int   mc, mRow, mIdx, mData, settleAt, decideAt;
  logic mValid, mIdle, mDone;

  task automatic modelReset();
    mc = 0; mRow = 0; mIdx = 0; mData = 0; settleAt = -1; decideAt = -1;
    mValid = 1'b0; mIdle = 1'b1; mDone = 1'b0;
  endtask

  task automatic modelStep(input logic en, input logic rdy);
    logic nValid, nIdle, nDone;
    nValid = mValid;
    nIdle  = mIdle;
    nDone  = 1'b0;
    if (mIdle && en) begin
      nIdle = 1'b0;
      settleAt = mc + 1;
    end
    if (mc == settleAt) begin
      if (rowMask[mRow]) begin
        nDone = (mRow == NR - 1);
        mRow = (mRow + 1) % NR;
        decideAt = mc + TD;
      end else begin
        nValid = 1'b1;
        mIdx = mRow;
        mData = int'(muxRows[mRow]);
      end
    end
    if (mValid && rdy) begin
      nValid = 1'b0;
      nDone = (mRow == NR - 1);
      mRow = (mRow + 1) % NR;
      decideAt = mc + TD;
    end
    if (mc == decideAt) begin
      if (en) settleAt = mc + 1;
      else begin
        nIdle = 1'b1;
        mRow = 0;
      end
    end
    mValid = nValid;
    mIdle = nIdle;
    mDone = nDone;
    mc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c, doneCnt, firstDone;
    for (int k = 0; k < NR; k++) muxRows[k] = 8'(8'hA0 + k);

    tbl[0]  = mk(1, 1, 0, 0, 'h00, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 'h00, 0, 0, 1);
    tbl[2]  = mk(1, 1, 1, 0, 'hA0, 0, 0, 1);
    tbl[3]  = mk(1, 1, 0, 0, 'hA0, 1, 0, 1);
    tbl[4]  = mk(1, 1, 0, 0, 'hA0, 1, 0, 1);
    tbl[5]  = mk(1, 1, 0, 0, 'hA0, 1, 0, 1);
    tbl[6]  = mk(1, 1, 0, 0, 'hA0, 1, 0, 1);
    tbl[7]  = mk(1, 1, 0, 0, 'hA0, 1, 0, 1);
    tbl[8]  = mk(1, 1, 1, 1, 'hA1, 1, 0, 1);
    tbl[9]  = mk(1, 1, 0, 1, 'hA1, 2, 0, 1);
    tbl[10] = mk(1, 1, 0, 1, 'hA1, 2, 0, 1);
    tbl[11] = mk(1, 1, 0, 1, 'hA1, 2, 0, 1);
    tbl[12] = mk(1, 1, 0, 1, 'hA1, 2, 0, 1);
    tbl[13] = mk(1, 1, 0, 1, 'hA1, 2, 0, 1);
    tbl[14] = mk(1, 1, 1, 2, 'hA2, 2, 0, 1);
    tbl[15] = mk(1, 1, 0, 2, 'hA2, 3, 0, 1);

    // Test 1: full frame timing from the vector table, then row 9 and the wrap.
    doReset();
    check("reset state", outVec(), expVec(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) begin
      enable = tbl[i].en;
      ready = tbl[i].rdy;
      check($sformatf("tbl[%0d]", i), outVec(),
            expVec(tbl[i].v, tbl[i].idx, tbl[i].data, tbl[i].s, tbl[i].done, tbl[i].bsy));
      tick();
    end
    c = 16;
    doneCnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rowValid && rowIdx == 4'd9) begin
        ok = 1'b1;
        break;
      end
      if (frameDone) doneCnt++;
      tick();
      c++;
    end
    check("row9 reached", 32'(ok), 32'd1);
    check("row9 cycle", 32'(c), 32'd56);
    check("no early frame_done", 32'(doneCnt), 32'd0);
    check("row9 present", outVec(), expVec(1, 9, 'hA9, 9, 0, 1));
    tick();
    check("frame_done after row9", outVec(), expVec(0, 9, 'hA9, 0, 1, 1));
    tick();
    check("frame_done one cycle", 32'(frameDone), 32'd0);
    repeat (4) tick();
    check("row0 second frame", outVec(), expVec(1, 0, 'hA0, 0, 0, 1));

    // Test 2: backpressure on row 5.
    waitRow(5, 1'b1, ok);
    check("wait row5", 32'(ok), 32'd1);
    for (int i = 0; i < 20; i++) begin
      ready = 1'b0;
      check("row5 held", outVec(), expVec(1, 5, 'hA5, 5, 0, 1));
      tick();
    end
    ready = 1'b1;
    check("row5 before accept", outVec(), expVec(1, 5, 'hA5, 5, 0, 1));
    tick();
    check("row5 accepted", outVec(), expVec(0, 5, 'hA5, 6, 0, 1));

    // Test 3: mux input changes while row 3 is presented.
    waitRow(3, 1'b1, ok);
    check("wait row3", 32'(ok), 32'd1);
    ready = 1'b0;
    muxRows[3] = 8'h5C;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("row3 data frozen", outVec(), expVec(1, 3, 'hA3, 3, 0, 1));
    end
    muxRows[3] = 8'hA3;
    ready = 1'b1;

    // Test 4: enable dropped during row 6.
    waitRow(6, 1'b1, ok);
    check("wait row6", 32'(ok), 32'd1);
    enable = 1'b0;
    ready = 1'b1;
    check("row6 present", outVec(), expVec(1, 6, 'hA6, 6, 0, 1));
    tick();
    for (int i = 0; i < TD; i++) begin
      check("row6 holdoff", outVec(), expVec(0, 6, 'hA6, 7, 0, 1));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      check("idle after disable", outVec(), expVec(0, 6, 'hA6, 0, 0, 0));
      tick();
    end
    enable = 1'b1;
    tick();
    check("re-enable settle", outVec(), expVec(0, 6, 'hA6, 0, 0, 1));
    tick();
    check("re-enable row0", outVec(), expVec(1, 0, 'hA0, 0, 0, 1));

    // Test 5: asynchronous reset during row 7 hold-off.
    waitRow(7, 1'b1, ok);
    check("wait row7", 32'(ok), 32'd1);
    tick();
    tick();
    check("row7 holdoff", outVec(), expVec(0, 7, 'hA7, 8, 0, 1));
    #2;
    rstN = 1'b0;
    #1;
    check("reset async", outVec(), expVec(0, 0, 0, 0, 0, 0));
    tick();
    check("reset held", outVec(), expVec(0, 0, 0, 0, 0, 0));
    rstN = 1'b1;
    enable = 1'b1;
    ready = 1'b1;
    tick();
    check("post-reset settle", outVec(), expVec(0, 0, 0, 0, 0, 1));
    tick();
    check("post-reset row0", outVec(), expVec(1, 0, 'hA0, 0, 0, 1));

`ifdef MUXSCHED_ROWMASK_EN
    // Test 6: masked rows 2 and 5, then every row masked.
    doReset();
    rowMask = 10'b0000100100;
    enable = 1'b1;
    ready = 1'b1;
    doneCnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 130; i++) begin
      if (rowValid && (rowIdx == 4'd2 || rowIdx == 4'd5)) ok = 1'b1;
      if (frameDone) doneCnt++;
      tick();
    end
    check("masked rows never valid", 32'(ok), 32'd0);
    check("masked frame_done count", 32'(doneCnt), 32'd2);

    doReset();
    rowMask = '1;
    enable = 1'b1;
    ready = 1'b1;
    ok = 1'b0;
    doneCnt = 0;
    firstDone = -1;
    for (int i = 0; i < 160; i++) begin
      if (rowValid) ok = 1'b1;
      if (frameDone) begin
        if (firstDone < 0) firstDone = i;
        else check("all-masked period", 32'(i - firstDone - 50 * doneCnt), 32'd50);
        if (firstDone >= 0 && i != firstDone) doneCnt++;
      end
      tick();
    end
    check("all masked no valid", 32'(ok), 32'd0);
    check("all masked first done", 32'(firstDone), 32'd47);
    check("all masked later dones", 32'(doneCnt), 32'd2);
`endif

    // Randomized run against the reference model.
    doReset();
    for (int k = 0; k < NR; k++) muxRows[k] = 8'($urandom);
`ifdef MUXSCHED_ROWMASK_EN
    rowMask = NR'($urandom);
`endif
    modelReset();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      check("random", outVec(), expVec(mValid, mIdx, mData, mRow, mDone, !mIdle));
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      ready = ($urandom_range(0, 3) != 0);
      modelStep(enable, ready);
      tick();
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
